// File: rtl/latency_dram.sv
// Byte-addressed big-endian 32-bit memory with programmable access latency and a stall handshake.
// Optional alignment checking is enabled by defining DRAM_ALIGN_CHECK_EN.
module latency_dram #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int LATENCY     = 2,
    parameter     MEMORY_FILE = "dm.hex"
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ,
    input  logic                  WEN,
    input  logic [2:0]            wwide,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    output logic                  stall,
    output logic                  misalign
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  lat_wen;
    logic [2:0]            lat_wwide;
    logic [31:0]           lat_wdata;

    logic [ADDR_WIDTH-1:0] src_addr;
    logic                  src_wen;
    logic [ADDR_WIDTH-1:0] a1, a2, a3;
    logic [31:0]           rd_word;
    logic                  enter_done;
    logic                  wr_block;

    // In IDLE the live inputs address the array so a LATENCY=1 read can capture on the same edge.
    always_comb begin
        src_addr   = lat_addr;
        src_wen    = lat_wen;
        enter_done = 1'b0;
        if (state == S_IDLE) begin
            src_addr   = addr;
            src_wen    = WEN;
            enter_done = REQ && (LATENCY == 1);
        end else if (state == S_WAIT) begin
            enter_done = (cnt == 4'd1);
        end
        a1      = src_addr + ADDR_WIDTH'(1);
        a2      = src_addr + ADDR_WIDTH'(2);
        a3      = src_addr + ADDR_WIDTH'(3);
        rd_word = {mem[src_addr], mem[a1], mem[a2], mem[a3]};
    end

    assign stall = ((state == S_IDLE) && REQ) || (state == S_WAIT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rdata     <= '0;
            lat_addr  <= '0;
            lat_wen   <= 1'b0;
            lat_wwide <= '0;
            lat_wdata <= '0;
        end else begin
            if (enter_done && !src_wen)
                rdata <= rd_word;
            case (state)
                S_IDLE: begin
                    if (REQ) begin
                        lat_addr  <= addr;
                        lat_wen   <= WEN;
                        lat_wwide <= wwide;
                        lat_wdata <= wdata;
                        cnt       <= 4'(LATENCY - 1);
                        state     <= (LATENCY == 1) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DRAM_ALIGN_CHECK_EN
    logic [2:0] src_wwide;
    logic       src_misal;
    logic       misalign_q;

    always_comb begin
        src_wwide = (state == S_IDLE) ? wwide : lat_wwide;
        if (src_wen)
            src_misal = ((src_wwide == 3'd2) && src_addr[0]) ||
                        ((src_wwide == 3'd4) && (src_addr[1:0] != 2'b00));
        else
            src_misal = (src_addr[1:0] != 2'b00);
    end

    // Flag and write-suppress decisions are taken on entry to DONE, from the latched request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            misalign_q <= 1'b0;
            wr_block   <= 1'b0;
        end else if (enter_done) begin
            wr_block <= src_misal;
            if (src_misal) begin
                misalign_q <= 1'b1;
                $display("misaligned access @%h", src_addr);
            end
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
    assign wr_block = 1'b0;
`endif

    // Big-endian: most-significant byte lands at the lowest (wrapped) address.
    always_ff @(posedge CLK) begin
        if (!RST && (state == S_DONE) && lat_wen && !wr_block) begin
            case (lat_wwide)
                3'd4: begin
                    mem[src_addr] <= lat_wdata[31:24];
                    mem[a1]       <= lat_wdata[23:16];
                    mem[a2]       <= lat_wdata[15:8];
                    mem[a3]       <= lat_wdata[7:0];
                end
                3'd2: begin
                    mem[src_addr] <= lat_wdata[15:8];
                    mem[a1]       <= lat_wdata[7:0];
                end
                3'd1:    mem[src_addr] <= lat_wdata[7:0];
                default: ;
            endcase
        end
    end

endmodule
